// File: rtl/lfsr_pkg.sv
// Shared LFSR types and the single-step reference function used by the core and
// by benches.
package lfsr_pkg;

  typedef enum logic {
    LFSR_FIB = 1'b0,
    LFSR_GAL = 1'b1
  } lfsr_mode_e;

  localparam int unsigned LfsrMaxWidth = 64;

  // One shift of a width-bit LFSR held in the low bits of a 64-bit word.
  function automatic logic [63:0] lfsr_step(input logic [63:0]   state,
                                            input logic [63:0]   taps,
                                            input lfsr_mode_e    mode,
                                            input int unsigned   width);
    logic [63:0] mask;
    logic [63:0] s;
    logic [63:0] t;
    logic        msb;
    mask = (64'd1 << width) - 64'd1;
    s    = state & mask;
    t    = taps & mask;
    msb  = |(s & (64'd1 << (width - 1)));
    if (mode == LFSR_FIB) begin
      lfsr_step = {s[62:0], ^(s & t)} & mask;
    end else begin
      lfsr_step = ({s[62:0], 1'b0} ^ (msb ? t : 64'd0)) & mask;
    end
  endfunction

endpackage

// File: rtl/lfsr_gen_if.sv
// Stream, reseed and status signals of the LFSR generator.
interface lfsr_gen_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
) ();

  logic             load_i;
  logic [WIDTH-1:0] seed_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] data_o;
  logic             wrap_o;
  logic [CNT_W-1:0] period_o;
  logic             zero_seed_o;

  modport master (
    input  load_i, seed_i, out_ready_i,
    output out_valid_o, data_o, wrap_o, period_o, zero_seed_o
  );

  modport slave (
    output load_i, seed_i, out_ready_i,
    input  out_valid_o, data_o, wrap_o, period_o, zero_seed_o
  );

endinterface

// File: rtl/lfsr_gen_core.sv
// Combinational next state: STEP single LFSR shifts chained in one cycle.
module lfsr_gen_core
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'hA,
  parameter lfsr_mode_e       MODE  = LFSR_FIB,
  parameter int unsigned      STEP  = 1
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = cur;
    for (int unsigned i = 0; i < STEP; i++) begin
      nxt = WIDTH'(lfsr_step(64'(nxt), 64'(TAPS), MODE, WIDTH));
    end
  end

endmodule

// File: rtl/lfsr_gen.sv
// LFSR pseudo-random stream source with runtime reseed, zero-seed guard and
// seed-to-seed period measurement.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'hA,
  parameter logic [WIDTH-1:0] SEED  = 4'hE,
  parameter int unsigned      MODE  = 0,
  parameter int unsigned      STEP  = 1,
  parameter int unsigned      CNT_W = 16
) (
  input logic        clk,
  input logic        reset,
  lfsr_gen_if.master bus
);

  localparam lfsr_mode_e ModeSel = (MODE == 0) ? LFSR_FIB : LFSR_GAL;

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WIDTH-1:0] step_nxt;
  logic [WIDTH-1:0] load_seed;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             zero_q, zero_d;
  logic             xfer;
  logic             sat;

  lfsr_gen_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .MODE  (ModeSel),
    .STEP  (STEP)
  ) u_core (
    .cur (state_q),
    .nxt (step_nxt)
  );

  always_comb begin
    xfer      = valid_q & bus.out_ready_i;
    sat       = &count_q;
    load_seed = (bus.seed_i == '0) ? SEED : bus.seed_i;
    state_d   = state_q;
    seed_d    = seed_q;
    count_d   = count_q;
    period_d  = period_q;
    valid_d   = 1'b1;
    wrap_d    = 1'b0;
    zero_d    = 1'b0;
    if (bus.load_i) begin
      state_d = load_seed;
      seed_d  = load_seed;
      count_d = '0;
      valid_d = 1'b0;
      zero_d  = (bus.seed_i == '0);
    end else if (xfer) begin
      state_d = step_nxt;
      // A saturated counter freezes period tracking until the next reseed.
      if (!sat) begin
        if (step_nxt == seed_q) begin
          wrap_d   = 1'b1;
          period_d = count_q + 1'b1;
          count_d  = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= SEED;
      seed_q   <= SEED;
      count_q  <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      seed_q   <= seed_d;
      count_q  <= count_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.out_valid_o = valid_q;
  assign bus.data_o      = state_q;
  assign bus.wrap_o      = wrap_q;
  assign bus.period_o    = period_q;
  assign bus.zero_seed_o = zero_q;

  state_nonzero_a : assert property (@(posedge clk) disable iff (!reset) state_q != '0);

endmodule
